// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART blocks (receiver now, transmitter later).
//   - rx_state_t   : receiver FSM state encoding
//   - clks_per_bit : clock cycles per serial bit (integer division)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2
//   Two-flop synchronizer for a single asynchronous input bit.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset (both flops load RESET_VAL)
//     d_i   in  asynchronous input
//     q_o   out synchronized output, two clocks of latency
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture chain; only sync_q is safe to use downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_hex.sv
// uart_rx_hex
//   8N1 UART receiver feeding the hex display with the last correctly framed byte.
//   Ports:
//     clk       in   system clock, all logic on posedge
//     rst_n     in   asynchronous active-low reset
//     rx        in   asynchronous serial input, idle high
//     hex_val   out  last good byte (8 bits), changes only together with valid
//     valid     out  one-cycle pulse when hex_val is updated
//     frame_err out  one-cycle pulse when the stop bit is sampled low
//     busy      out  high whenever the receiver is not in IDLE
module uart_rx_hex
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] hex_val,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    rx_state_t        state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic [7:0]       hex_val_q,  hex_val_d;
    logic             valid_q,    valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q,     busy_d;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // State, counters, data path and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            hex_val_q   <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hex_val_q   <= hex_val_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and output decode. The baud counter free-runs by default and is
    // cleared at every sample point, so it never wraps.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hex_val_d   = hex_val_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = 3'd0;
                if (!rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // Mid start bit: a high line here was only a glitch.
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                // Leave mid stop bit so an immediately following start edge is caught.
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    if (rx_s) begin
                        hex_val_d = shift_q;
                        valid_d   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                // Held-low line: wait for idle so no spurious start is decoded.
                baud_cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
                bit_cnt_d  = 3'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign hex_val   = hex_val_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_hex.sv
// tb_uart_rx_hex
//   Directed self-checking bench for uart_rx_hex at 12 MHz / 115200 baud (104 clk/bit).
module tb_uart_rx_hex;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] hex_val;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_rx_hex #(
        .CLK_FREQ (12_000_000),
        .BAUD     (115_200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .hex_val   (hex_val),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge (away from the active edge).
    int         valid_cnt  = 0;
    int         ferr_cnt   = 0;
    int         both_cnt   = 0;
    int         wide_cnt   = 0;
    int         hexchg_cnt = 0;
    int         valid_cyc  = 0;
    logic [7:0] vhist [0:63];
    logic [7:0] hex_prev   = 8'h00;
    logic       valid_prev = 1'b0;
    logic       ferr_prev  = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                vhist[valid_cnt[5:0]] = hex_val;
                valid_cnt = valid_cnt + 1;
                valid_cyc = cyc;
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (valid && frame_err) both_cnt = both_cnt + 1;
            if ((valid && valid_prev) || (frame_err && ferr_prev)) wide_cnt = wide_cnt + 1;
            if (!valid && (hex_val != hex_prev)) hexchg_cnt = hexchg_cnt + 1;
        end
        hex_prev   = hex_val;
        valid_prev = valid;
        ferr_prev  = frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; rx is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] data, input int cpb, input logic stop_bit);
        rx = 1'b0;
        repeat (cpb) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (cpb) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         cpb;
        logic       stop_bit;
        logic [7:0] exp_hex;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [7];

    int         vbase, fbase, hbase, start_cyc, lat;
    logic [7:0] hex_before;

    initial begin
        vecs[0] = '{data: 8'hA5, cpb: 104, stop_bit: 1'b1, exp_hex: 8'hA5, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h00, cpb: 104, stop_bit: 1'b1, exp_hex: 8'h00, exp_valid: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'hFF, cpb: 104, stop_bit: 1'b1, exp_hex: 8'hFF, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h5A, cpb: 102, stop_bit: 1'b1, exp_hex: 8'h5A, exp_valid: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h5A, cpb: 106, stop_bit: 1'b1, exp_hex: 8'h5A, exp_valid: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'h3C, cpb: 104, stop_bit: 1'b0, exp_hex: 8'h5A, exp_valid: 0, exp_ferr: 1};
        vecs[6] = '{data: 8'hC3, cpb: 104, stop_bit: 1'b1, exp_hex: 8'hC3, exp_valid: 1, exp_ferr: 0};

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_hex_val",   {24'd0, hex_val}, 32'h00);
        check("reset_valid",     {31'd0, valid},   32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy",      {31'd0, busy},    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);

        // Latency of the first frame (0xA5), measured from the start edge.
        vbase     = valid_cnt;
        start_cyc = cyc;
        send_frame(8'hA5, 104, 1'b1);
        idle(60);
        lat = valid_cyc - start_cyc;
        check("latency_in_990_991", {31'd0, (lat >= 990 && lat <= 991)}, 32'd1);
        check("latency_one_valid",  valid_cnt - vbase, 32'd1);

        // Table-driven frames.
        foreach (vecs[k]) begin
            vbase = valid_cnt;
            fbase = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].cpb, vecs[k].stop_bit);
            idle(150);
            check($sformatf("vec%0d_hex", k),   {24'd0, hex_val}, {24'd0, vecs[k].exp_hex});
            check($sformatf("vec%0d_valid", k), valid_cnt - vbase, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k),  ferr_cnt - fbase,  vecs[k].exp_ferr);
            check($sformatf("vec%0d_idle", k),  {31'd0, busy}, 32'd0);
        end

        // Back-to-back 0x00 then 0xFF, no idle gap.
        vbase = valid_cnt;
        fbase = ferr_cnt;
        send_frame(8'h00, 104, 1'b1);
        send_frame(8'hFF, 104, 1'b1);
        idle(150);
        check("b2b_valid_count", valid_cnt - vbase, 32'd2);
        check("b2b_first_hex",   {24'd0, vhist[vbase[5:0]]}, 32'h00);
        check("b2b_second_hex",  {24'd0, vhist[(vbase + 1) & 63]}, 32'hFF);
        check("b2b_no_ferr",     ferr_cnt - fbase, 32'd0);

        // Start glitch: low 30 clk.
        vbase      = valid_cnt;
        fbase      = ferr_cnt;
        hex_before = hex_val;
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        idle(200);
        check("glitch_no_valid", valid_cnt - vbase, 32'd0);
        check("glitch_no_ferr",  ferr_cnt - fbase,  32'd0);
        check("glitch_hex_kept", {24'd0, hex_val}, {24'd0, hex_before});
        check("glitch_idle",     {31'd0, busy}, 32'd0);

        // Bad stop bit followed by a long break.
        vbase      = valid_cnt;
        fbase      = ferr_cnt;
        hex_before = hex_val;
        send_frame(8'h3C, 104, 1'b0);
        repeat (2000) @(posedge clk);
        @(negedge clk);
        check("break_busy_held", {31'd0, busy}, 32'd1);
        check("break_one_ferr",  ferr_cnt - fbase, 32'd1);
        check("break_no_valid",  valid_cnt - vbase, 32'd0);
        check("break_hex_kept",  {24'd0, hex_val}, {24'd0, hex_before});
        idle(10);
        check("break_released_idle", {31'd0, busy}, 32'd0);
        idle(300);
        check("break_no_spurious", valid_cnt - vbase, 32'd0);

        // Reset during bit 4 of 0x81, then a clean 0x42.
        vbase = valid_cnt;
        rx = 1'b0;
        repeat (104) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            repeat (104) @(posedge clk);
            #1;
        end
        rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_hex_zero", {24'd0, hex_val}, 32'h00);
        check("midrst_busy",     {31'd0, busy},    32'd0);
        check("midrst_valid",    {31'd0, valid},   32'd0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(300);
        check("midrst_no_byte", valid_cnt - vbase, 32'd0);
        check("midrst_hex_held", {24'd0, hex_val}, 32'h00);
        send_frame(8'h42, 104, 1'b1);
        idle(150);
        check("after_rst_hex",   {24'd0, hex_val}, 32'h42);
        check("after_rst_valid", valid_cnt - vbase, 32'd1);

        // Global properties over the whole run.
        check("valid_ferr_exclusive", both_cnt,   32'd0);
        check("pulses_single_cycle",  wide_cnt,   32'd0);
        check("hex_changes_w_valid",  hexchg_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
